operand_read_stage: RTL and testbench

Register-read stage sitting between decode and execute, the read-side counterpart of the writeback stage's register-file write port. Accepts one decoded instruction per cycle, reads rs1/rs2 from the architectural `regfile` array, and tracks in-flight destination registers in a 32-entry busy scoreboard that writeback clears. Stalls on RAW and WAW hazards, with optional same-cycle writeback bypass. Presents a registered operand bundle to execute over a valid/ready handshake.

---
 rtl/operand_read_stage.sv | 189 ++++++++++++++++++
 tb/tb_operand_read_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_read_stage.sv
// operand_read_stage
// ------------------
// Register-read stage between decode and execute. Reads rs1/rs2 from the
// architectural register file and keeps a 32-entry busy scoreboard of
// in-flight destinations. Writeback clears busy bits. The stage stalls on
// RAW and WAW hazards. The operand bundle to execute is registered.
//
// Configuration macro: OPREAD_WB_BYPASS_EN
//   defined   : a writeback that hits a busy source in the same cycle removes
//               the hazard, and its wb_wdata is forwarded as the operand.
//   undefined : that source stalls one more cycle and then reads regfile.
//   In both builds, a same-cycle writeback to in_rd removes the WAW hazard.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid / in_ready          decode handshake (in_ready is combinational)
//   in_pc, in_inst, in_inst_id   passthrough fields
//   in_rs1/2, in_rs1/2_use       source indices and read enables
//   in_rd, in_rf_wen             destination
//   regfile                      architectural registers from writeback
//   wb_valid, wb_rf_wen,
//   wb_reg_addr, wb_wdata        value writeback commits at this posedge
//   out_valid / out_ready        execute handshake
//   out_*                        registered bundle
//   busy_mask                    scoreboard, bit 0 always 0
//   stall_count                  saturating count of hazard-stall cycles
//
// Handshakes: a transfer happens on a cycle where valid & ready are both high
// at the posedge. A producer holds valid and its data stable until then.
module operand_read_stage #(
  parameter int STALL_CNT_W = 32,
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32,
  parameter int IID_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [IID_W-1:0]           in_inst_id,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic                       in_rs1_use,
  input  logic                       in_rs2_use,
  input  logic [4:0]                 in_rd,
  input  logic                       in_rf_wen,
  input  logic [31:0][XLEN-1:0]      regfile,
  input  logic                       wb_valid,
  input  logic                       wb_rf_wen,
  input  logic [4:0]                 wb_reg_addr,
  input  logic [XLEN-1:0]            wb_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [IID_W-1:0]           out_inst_id,
  output logic [4:0]                 out_rd,
  output logic                       out_rf_wen,
  output logic [XLEN-1:0]            out_rs1_data,
  output logic [XLEN-1:0]            out_rs2_data,
  output logic [31:0]                busy_mask,
  output logic [STALL_CNT_W-1:0]     stall_count
);

  logic                   out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]      out_pc_q, out_pc_d;
  logic [INST_W-1:0]      out_inst_q, out_inst_d;
  logic [IID_W-1:0]       out_inst_id_q, out_inst_id_d;
  logic [4:0]             out_rd_q, out_rd_d;
  logic                   out_rf_wen_q, out_rf_wen_d;
  logic [XLEN-1:0]        out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0]        out_rs2_data_q, out_rs2_data_d;
  logic [31:0]            busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic [31:0]            wb_clr;
  logic                   byp_rs1, byp_rs2;
  logic                   hz_rs1, hz_rs2, waw;
  logic                   fire;
  logic [XLEN-1:0]        rs1_data, rs2_data;

  // Per-register clear from writeback. x0 is never tracked.
  always_comb begin
    wb_clr = '0;
    for (int r = 1; r < 32; r++) begin
      wb_clr[r] = wb_valid & wb_rf_wen & (wb_reg_addr == 5'(r));
    end
  end

`ifdef OPREAD_WB_BYPASS_EN
  assign byp_rs1 = wb_clr[in_rs1];
  assign byp_rs2 = wb_clr[in_rs2];
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  assign hz_rs1 = in_rs1_use & (in_rs1 != 5'd0) & busy_q[in_rs1] & ~byp_rs1;
  assign hz_rs2 = in_rs2_use & (in_rs2 != 5'd0) & busy_q[in_rs2] & ~byp_rs2;
  // A writeback retiring the old producer of in_rd this cycle removes the
  // WAW conflict in both builds. The new producer then re-sets the bit.
  assign waw    = in_rf_wen & (in_rd != 5'd0) & busy_q[in_rd] & ~wb_clr[in_rd];

  assign in_ready = (~out_valid_q | out_ready) & ~hz_rs1 & ~hz_rs2 & ~waw;
  assign fire     = in_valid & in_ready;

  always_comb begin
    rs1_data = regfile[in_rs1];
    if (!in_rs1_use || in_rs1 == 5'd0) rs1_data = '0;
    else if (byp_rs1)                  rs1_data = wb_wdata;
    rs2_data = regfile[in_rs2];
    if (!in_rs2_use || in_rs2 == 5'd0) rs2_data = '0;
    else if (byp_rs2)                  rs2_data = wb_wdata;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_inst_d     = out_inst_q;
    out_inst_id_d  = out_inst_id_q;
    out_rd_d       = out_rd_q;
    out_rf_wen_d   = out_rf_wen_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    if (fire) begin
      out_valid_d    = 1'b1;
      out_pc_d       = in_pc;
      out_inst_d     = in_inst;
      out_inst_id_d  = in_inst_id;
      out_rd_d       = in_rd;
      out_rf_wen_d   = in_rf_wen;
      out_rs1_data_d = rs1_data;
      out_rs2_data_d = rs2_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first, then set, so a new producer wins over a retiring one.
    busy_d = busy_q & ~wb_clr;
    if (fire && in_rf_wen && in_rd != 5'd0) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // Only hazard stalls count. Backpressure-only stalls do not.
    stall_count_d = stall_count_q;
    if (in_valid && (hz_rs1 || hz_rs2 || waw) && stall_count_q != '1)
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_inst_q     <= '0;
      out_inst_id_q  <= '0;
      out_rd_q       <= '0;
      out_rf_wen_q   <= 1'b0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      busy_q         <= '0;
      stall_count_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_inst_q     <= out_inst_d;
      out_inst_id_q  <= out_inst_id_d;
      out_rd_q       <= out_rd_d;
      out_rf_wen_q   <= out_rf_wen_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      busy_q         <= busy_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_inst     = out_inst_q;
  assign out_inst_id  = out_inst_id_q;
  assign out_rd       = out_rd_q;
  assign out_rf_wen   = out_rf_wen_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign busy_mask    = busy_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_operand_read_stage.sv
// Directed testbench for operand_read_stage. Expectations for the bypass
// scenario follow OPREAD_WB_BYPASS_EN when it is defined for the bench.
module tb_operand_read_stage;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_inst;
  logic [7:0]        in_inst_id;
  logic [4:0]        in_rs1, in_rs2;
  logic              in_rs1_use, in_rs2_use;
  logic [4:0]        in_rd;
  logic              in_rf_wen;
  logic [31:0][31:0] rf;
  logic              wb_valid, wb_rf_wen;
  logic [4:0]        wb_reg_addr;
  logic [31:0]       wb_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [7:0]        out_inst_id;
  logic [4:0]        out_rd;
  logic              out_rf_wen;
  logic [31:0]       out_rs1_data, out_rs2_data;
  logic [31:0]       busy_mask;
  logic [31:0]       stall_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 0;

  operand_read_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_inst_id(in_inst_id),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .regfile(rf),
    .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen),
    .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_inst_id(out_inst_id),
    .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks. Inputs change 1 time unit after the posedge. Checks happen
  // 2 time units after the posedge, well away from both clock edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_inst = 0; in_inst_id = 0;
    in_rs1 = 0; in_rs2 = 0; in_rs1_use = 0; in_rs2_use = 0;
    in_rd = 0; in_rf_wen = 0;
    wb_valid = 0; wb_rf_wen = 0; wb_reg_addr = 0; wb_wdata = 0;
    out_ready = 1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1; in_pc = pc; in_inst = pc ^ 32'h0000_0013; in_inst_id = pc[9:2];
    in_rs1 = rs1; in_rs1_use = u1; in_rs2 = rs2; in_rs2_use = u2;
    in_rd = rd; in_rf_wen = wen;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_rf_wen = 1; wb_reg_addr = a; wb_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[3] = 32'h33; rf[5] = 32'h1111_1111;
    #12;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0h want 0", out_valid); errors++; end
    checks++;
    if (busy_mask !== 32'h0) begin $display("FAIL reset_busy got %h want 0", busy_mask); errors++; end
    checks++;
    if (stall_count !== 32'h0) begin $display("FAIL reset_stall got %0d want 0", stall_count); errors++; end
    checks++;
    if (out_rs1_data !== 32'h0 || out_pc !== 32'h0) begin
      $display("FAIL reset_data got rs1=%h pc=%h want 0", out_rs1_data, out_pc); errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %0h want 1", in_ready); errors++; end
    checks++;
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_issue();
    offer(32'h100, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    if (in_ready !== 1'b1) begin $display("FAIL issue_in_ready got %0h want 1", in_ready); errors++; end
    checks++;
    tick(); idle_inputs(); #1;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_rd !== 5'd5 || out_rf_wen !== 1'b1) begin
      $display("FAIL issue_out got v=%0h pc=%h rd=%0d wen=%0h want v=1 pc=100 rd=5 wen=1",
               out_valid, out_pc, out_rd, out_rf_wen); errors++;
    end
    checks++;
    if (busy_mask !== 32'h20) begin $display("FAIL issue_busy got %h want 00000020", busy_mask); errors++; end
    checks++;
    tick(); #1;
    if (out_valid !== 1'b0) begin $display("FAIL issue_drain got %0h want 0", out_valid); errors++; end
    checks++;
  endtask

  task automatic test_raw();
    // Hazard present but not offered: must not count.
    in_rs1 = 5'd5; in_rs1_use = 1; tick(); #1;
    if (stall_count !== exp_stall) begin $display("FAIL raw_idle_stall got %0d want %0d", stall_count, exp_stall); errors++; end
    checks++;
    offer(32'h200, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1);
    #1;
    if (in_ready !== 1'b0) begin $display("FAIL raw_in_ready got %0h want 0", in_ready); errors++; end
    checks++;
    tick(); exp_stall++; #1;
    if (stall_count !== exp_stall) begin $display("FAIL raw_stall got %0d want %0d", stall_count, exp_stall); errors++; end
    checks++;
    wb(5'd5, 32'hDEAD_BEEF);
    #1;
`ifdef OPREAD_WB_BYPASS_EN
    if (in_ready !== 1'b1) begin $display("FAIL raw_byp_ready got %0h want 1", in_ready); errors++; end
    checks++;
    tick(); rf[5] = 32'hDEAD_BEEF; wb_valid = 0; wb_rf_wen = 0;
`else
    if (in_ready !== 1'b0) begin $display("FAIL raw_nobyp_ready got %0h want 0", in_ready); errors++; end
    checks++;
    tick(); rf[5] = 32'hDEAD_BEEF; wb_valid = 0; wb_rf_wen = 0; exp_stall++; #1;
    if (out_valid !== 1'b0 || busy_mask !== 32'h0) begin
      $display("FAIL raw_nobyp_wait got v=%0h busy=%h want v=0 busy=0", out_valid, busy_mask); errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL raw_nobyp_ready2 got %0h want 1", in_ready); errors++; end
    checks++;
    tick();
`endif
    idle_inputs(); wb(5'd6, 32'h66); #1;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'hDEAD_BEEF || out_rs2_data !== 32'h33 || out_pc !== 32'h200) begin
      $display("FAIL raw_data got v=%0h rs1=%h rs2=%h pc=%h want v=1 rs1=deadbeef rs2=33 pc=200",
               out_valid, out_rs1_data, out_rs2_data, out_pc); errors++;
    end
    checks++;
    if (busy_mask !== 32'h40 || stall_count !== exp_stall) begin
      $display("FAIL raw_busy got busy=%h stall=%0d want busy=00000040 stall=%0d", busy_mask, stall_count, exp_stall); errors++;
    end
    checks++;
    tick(); rf[6] = 32'h66; idle_inputs(); #1;
    if (busy_mask !== 32'h0) begin $display("FAIL raw_wb_clear got %h want 0", busy_mask); errors++; end
    checks++;
  endtask

  task automatic test_zero_back_to_back();
    rf[0] = 32'hBADB_ADBA;
    offer(32'h204, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    if (in_ready !== 1'b1) begin $display("FAIL zero_ready got %0h want 1", in_ready); errors++; end
    checks++;
    tick();
    offer(32'h208, 5'd3, 1'b0, 5'd3, 1'b1, 5'd9, 1'b0);
    #1;
    if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0 || out_valid !== 1'b1 || busy_mask !== 32'h0) begin
      $display("FAIL zero_ops got rs1=%h rs2=%h v=%0h busy=%h want 0 0 1 0",
               out_rs1_data, out_rs2_data, out_valid, busy_mask); errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL b2b_ready got %0h want 1", in_ready); errors++; end
    checks++;
    tick(); idle_inputs(); #1;
    if (out_pc !== 32'h208 || out_rs1_data !== 32'h0 || out_rs2_data !== 32'h33 || busy_mask !== 32'h0) begin
      $display("FAIL b2b_ops got pc=%h rs1=%h rs2=%h busy=%h want 208 0 33 0",
               out_pc, out_rs1_data, out_rs2_data, busy_mask); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_waw();
    offer(32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    offer(32'h304, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    if (in_ready !== 1'b0 || busy_mask !== 32'h80) begin
      $display("FAIL waw_block got rdy=%0h busy=%h want 0 00000080", in_ready, busy_mask); errors++;
    end
    checks++;
    tick(); exp_stall++;
    wb(5'd7, 32'h77);
    #1;
    if (in_ready !== 1'b1 || stall_count !== exp_stall) begin
      $display("FAIL waw_clear_ready got rdy=%0h stall=%0d want 1 %0d", in_ready, stall_count, exp_stall); errors++;
    end
    checks++;
    tick(); rf[7] = 32'h77; idle_inputs(); #1;
    if (out_valid !== 1'b1 || out_pc !== 32'h304 || busy_mask !== 32'h80 || stall_count !== exp_stall) begin
      $display("FAIL waw_set_wins got v=%0h pc=%h busy=%h stall=%0d want 1 304 00000080 %0d",
               out_valid, out_pc, busy_mask, stall_count, exp_stall); errors++;
    end
    checks++;
  endtask

  task automatic test_backpressure_reset();
    out_ready = 0;
    offer(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h304 || in_ready !== 1'b0 ||
          stall_count !== exp_stall || busy_mask !== 32'h80) begin
        $display("FAIL hold_c%0d got v=%0h pc=%h rdy=%0h stall=%0d busy=%h want 1 304 0 %0d 00000080",
                 c, out_valid, out_pc, in_ready, stall_count, exp_stall, busy_mask); errors++;
      end
      checks++;
      tick();
    end
    #2 rst_n = 0;
    #1;
    if (out_valid !== 1'b0 || busy_mask !== 32'h0 || stall_count !== 32'h0 || out_pc !== 32'h0) begin
      $display("FAIL async_reset got v=%0h busy=%h stall=%0d pc=%h want 0 0 0 0",
               out_valid, busy_mask, stall_count, out_pc); errors++;
    end
    checks++;
    idle_inputs();
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw();
    test_zero_back_to_back();
    test_waw();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
